// File: rtl/lsu_mem_master_pkg.sv
// Shared types and constants for the load/store memory master.
package lsu_mem_master_pkg;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned WMASK_W = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;
endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: write mask/data shifting, misalignment detection and
// sign/zero extension of load data.
module lsu_align
  import lsu_mem_master_pkg::*;
(
  input  logic [1:0]         addr_lo,
  input  logic [1:0]         size,
  input  logic               is_unsigned,
  input  logic               wen,
  input  logic [XLEN-1:0]    wdata,
  input  logic [XLEN-1:0]    rdata,
  output logic [WMASK_W-1:0] wmask,
  output logic [XLEN-1:0]    wdata_sh,
  output logic               misalign,
  output logic [XLEN-1:0]    load_data
);
  logic [4:0]      shamt;
  logic [XLEN-1:0] shifted;
  logic            sx;

  always_comb begin
    shamt     = {addr_lo, 3'b000};
    wdata_sh  = wdata << shamt;
    shifted   = rdata >> shamt;
    sx        = ~is_unsigned;
    wmask     = '0;
    misalign  = 1'b0;
    load_data = shifted;
    case (size)
      SZ_B: begin
        wmask     = 8'h01 << addr_lo;
        load_data = {{(XLEN-8){sx & shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        wmask     = 8'h03 << addr_lo;
        misalign  = addr_lo[0];
        load_data = {{(XLEN-16){sx & shifted[15]}}, shifted[15:0]};
      end
      SZ_W: begin
        wmask    = 8'h0F;
        misalign = |addr_lo;
      end
      default: misalign = 1'b1;
    endcase
    if (!wen) wmask = '0;
  end
endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator: one request at a time, single-cycle SRAM access,
// registered read capture and extended response.
module lsu_mem_master
  import lsu_mem_master_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_wen,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  output logic        mem_wen,
  output logic        mem_valid,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

  state_e      state, state_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q, cnt_q;
  logic        wen_q, uns_q, err_q;

  logic [1:0]         al_addr, al_size;
  logic               al_uns, al_wen, al_misalign;
  logic [31:0]        al_wdata, al_wdata_sh, al_load;
  logic [WMASK_W-1:0] al_wmask;

  // One aligner serves both phases: live request fields in IDLE (for the
  // accept-time misalignment check), latched fields afterwards.
  always_comb begin
    if (state == IDLE) begin
      al_addr  = req_addr[1:0];
      al_size  = req_size;
      al_uns   = req_unsigned;
      al_wen   = req_wen;
      al_wdata = req_wdata;
    end else begin
      al_addr  = addr_q[1:0];
      al_size  = size_q;
      al_uns   = uns_q;
      al_wen   = wen_q;
      al_wdata = wdata_q;
    end
  end

  lsu_align u_align (
    .addr_lo     (al_addr),
    .size        (al_size),
    .is_unsigned (al_uns),
    .wen         (al_wen),
    .wdata       (al_wdata),
    .rdata       (mem_rdata),
    .wmask       (al_wmask),
    .wdata_sh    (al_wdata_sh),
    .misalign    (al_misalign),
    .load_data   (al_load)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          wen_q   <= req_wen;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          err_q   <= al_misalign;
          rdata_q <= '0;
        end
        REQ: cnt_q <= CNT_INIT;
        WAIT: begin
          if (cnt_q == '0) begin
            if (!wen_q) rdata_q <= al_load;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_valid  = 1'b0;
    mem_wen    = 1'b0;
    mem_wmask  = '0;
    mem_raddr  = '0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = al_misalign ? RESP : REQ;
      end
      REQ: begin
        mem_valid = 1'b1;
        mem_wen   = wen_q;
        mem_wmask = al_wmask;
        mem_raddr = {addr_q[31:2], 2'b00};
        mem_waddr = {addr_q[31:2], 2'b00};
        mem_wdata = al_wdata_sh;
        state_nxt = WAIT;
      end
      WAIT: if (cnt_q == '0) state_nxt = RESP;
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a small registered SRAM model.
module tb_lsu_mem_master;
  localparam int LAT = 1;

  logic        clk, rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_raddr, mem_waddr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        mem_wen, mem_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] c_rd, c_waddr, c_raddr, c_wdata;
  logic [7:0]  c_wmask;
  logic        c_err, c_mv, c_mwen;
  int          c_lat;

  lsu_mem_master #(.RD_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wen(req_wen), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_wen(mem_wen), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered single-port SRAM, 16 words, read data one cycle after strobe.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (mem_valid) begin
      if (mem_wen)
        for (int i = 0; i < 4; i++)
          if (mem_wmask[i]) mem[mem_waddr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
      mem_rdata <= mem[mem_raddr[5:2]];
    end
  end

  // Drives one transaction with resp_ready=1 and records what was seen.
  // c_lat counts cycles from the accept edge until resp_valid is observed.
  task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic w,
                         input logic [1:0] sz, input logic u);
    req_addr = a; req_wdata = d; req_wen = w; req_size = sz; req_unsigned = u;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    c_lat = 1; c_mv = 1'b0; c_waddr = '0; c_raddr = '0; c_wdata = '0; c_wmask = '0; c_mwen = 1'b0;
    while (!resp_valid && c_lat < 20) begin
      if (mem_valid) begin
        c_mv = 1'b1; c_waddr = mem_waddr; c_raddr = mem_raddr;
        c_wdata = mem_wdata; c_wmask = mem_wmask; c_mwen = mem_wen;
      end
      @(posedge clk); #1;
      c_lat++;
    end
    c_rd = resp_rdata; c_err = resp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; req_addr = '0; req_wdata = '0;
    req_wen = 1'b0; req_size = '0; req_unsigned = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
    n_cmp++; if ({resp_err, resp_rdata} !== 33'd0) begin n_bad++; $display("FAIL rst_resp: got %b/%h expected 0/0", resp_err, resp_rdata); end
    n_cmp++; if ({mem_valid, mem_wen, mem_wmask} !== 10'd0) begin n_bad++; $display("FAIL rst_mem_ctl: got %b %b %h expected 0", mem_valid, mem_wen, mem_wmask); end
    n_cmp++; if ({mem_raddr, mem_waddr, mem_wdata} !== 96'd0) begin n_bad++; $display("FAIL rst_mem_bus: got %h %h %h expected 0", mem_raddr, mem_waddr, mem_wdata); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store_load();
    run_req(32'h8000_0004, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0);
    n_cmp++; if (c_mv !== 1'b1) begin n_bad++; $display("FAIL sw_mem_valid: got %b expected 1", c_mv); end
    n_cmp++; if (c_waddr !== 32'h8000_0004) begin n_bad++; $display("FAIL sw_waddr: got %h expected 80000004", c_waddr); end
    n_cmp++; if (c_raddr !== 32'h8000_0004) begin n_bad++; $display("FAIL sw_raddr: got %h expected 80000004", c_raddr); end
    n_cmp++; if (c_wmask !== 8'h0F) begin n_bad++; $display("FAIL sw_wmask: got %h expected 0f", c_wmask); end
    n_cmp++; if (c_mwen !== 1'b1) begin n_bad++; $display("FAIL sw_wen: got %b expected 1", c_mwen); end
    n_cmp++; if (c_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_wdata: got %h expected deadbeef", c_wdata); end
    n_cmp++; if ({c_err, c_rd} !== 33'd0) begin n_bad++; $display("FAIL sw_resp: got %b/%h expected 0/0", c_err, c_rd); end
    n_cmp++; if (c_lat !== LAT + 2) begin n_bad++; $display("FAIL sw_latency: got %0d expected %0d", c_lat, LAT + 2); end
    run_req(32'h8000_0004, 32'h0, 1'b0, 2'd2, 1'b0);
    n_cmp++; if (c_rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_rdata: got %h expected deadbeef", c_rd); end
    n_cmp++; if (c_lat !== LAT + 2) begin n_bad++; $display("FAIL lw_latency: got %0d expected %0d", c_lat, LAT + 2); end
    n_cmp++; if ({c_mwen, c_wmask} !== 9'd0) begin n_bad++; $display("FAIL lw_no_write: got %b %h expected 0 00", c_mwen, c_wmask); end
  endtask

  task automatic test_byte_store();
    run_req(32'h8000_0003, 32'h0000_00AB, 1'b1, 2'd0, 1'b0);
    n_cmp++; if (c_wmask !== 8'h08) begin n_bad++; $display("FAIL sb_wmask: got %h expected 08", c_wmask); end
    n_cmp++; if (c_wdata !== 32'hAB00_0000) begin n_bad++; $display("FAIL sb_wdata: got %h expected ab000000", c_wdata); end
    n_cmp++; if (c_waddr !== 32'h8000_0000) begin n_bad++; $display("FAIL sb_waddr: got %h expected 80000000", c_waddr); end
    run_req(32'h8000_0000, 32'h0, 1'b0, 2'd2, 1'b0);
    n_cmp++; if (c_rd !== 32'hAB00_0000) begin n_bad++; $display("FAIL sb_readback: got %h expected ab000000", c_rd); end
  endtask

  task automatic test_ext_loads();
    run_req(32'h8000_0008, 32'h80FF_7F01, 1'b1, 2'd2, 1'b0);
    run_req(32'h8000_0009, 32'h0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (c_rd !== 32'h0000_007F) begin n_bad++; $display("FAIL lb_1: got %h expected 0000007f", c_rd); end
    run_req(32'h8000_000B, 32'h0, 1'b0, 2'd0, 1'b0);
    n_cmp++; if (c_rd !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_3: got %h expected ffffff80", c_rd); end
    run_req(32'h8000_000B, 32'h0, 1'b0, 2'd0, 1'b1);
    n_cmp++; if (c_rd !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_3: got %h expected 00000080", c_rd); end
    run_req(32'h8000_000A, 32'h0, 1'b0, 2'd1, 1'b1);
    n_cmp++; if (c_rd !== 32'h0000_80FF) begin n_bad++; $display("FAIL lhu_2: got %h expected 000080ff", c_rd); end
    run_req(32'h8000_000A, 32'h0, 1'b0, 2'd1, 1'b0);
    n_cmp++; if (c_rd !== 32'hFFFF_80FF) begin n_bad++; $display("FAIL lh_2: got %h expected ffff80ff", c_rd); end
    run_req(32'h8000_0008, 32'h0, 1'b0, 2'd1, 1'b0);
    n_cmp++; if (c_rd !== 32'h0000_7F01) begin n_bad++; $display("FAIL lh_0: got %h expected 00007f01", c_rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] addrs [3] = '{32'h8000_0002, 32'h8000_0000, 32'h8000_0001};
    logic [1:0]  sizes [3] = '{2'd2, 2'd3, 2'd1};
    for (int i = 0; i < 3; i++) begin
      run_req(addrs[i], 32'h1234_5678, 1'b0, sizes[i], 1'b0);
      n_cmp++; if (c_err !== 1'b1) begin n_bad++; $display("FAIL mis_err[%0d]: got %b expected 1", i, c_err); end
      n_cmp++; if (c_rd !== 32'h0) begin n_bad++; $display("FAIL mis_rdata[%0d]: got %h expected 0", i, c_rd); end
      n_cmp++; if (c_mv !== 1'b0) begin n_bad++; $display("FAIL mis_mem_valid[%0d]: got %b expected 0", i, c_mv); end
      n_cmp++; if (c_lat !== 1) begin n_bad++; $display("FAIL mis_latency[%0d]: got %0d expected 1", i, c_lat); end
    end
    run_req(32'h8000_0006, 32'hFFFF_FFFF, 1'b1, 2'd2, 1'b0);
    n_cmp++; if ({c_err, c_mv} !== 2'b10) begin n_bad++; $display("FAIL mis_store: got err=%b mv=%b expected err=1 mv=0", c_err, c_mv); end
  endtask

  task automatic test_back_to_back();
    run_req(32'h8000_000E, 32'h0000_1234, 1'b1, 2'd1, 1'b0);
    n_cmp++; if (c_wmask !== 8'h0C) begin n_bad++; $display("FAIL sh_wmask: got %h expected 0c", c_wmask); end
    n_cmp++; if (c_wdata !== 32'h1234_0000) begin n_bad++; $display("FAIL sh_wdata: got %h expected 12340000", c_wdata); end
    n_cmp++; if ({req_ready, resp_valid} !== 2'b10) begin n_bad++; $display("FAIL b2b_idle: got ready=%b valid=%b expected 1/0", req_ready, resp_valid); end
    run_req(32'h8000_000E, 32'h0, 1'b0, 2'd1, 1'b1);
    n_cmp++; if (c_rd !== 32'h0000_1234) begin n_bad++; $display("FAIL b2b_lhu: got %h expected 00001234", c_rd); end
    n_cmp++; if (c_lat !== LAT + 2) begin n_bad++; $display("FAIL b2b_latency: got %0d expected %0d", c_lat, LAT + 2); end
    run_req(32'h8000_000C, 32'h0, 1'b0, 2'd2, 1'b0);
    n_cmp++; if (c_rd !== 32'h1234_0000) begin n_bad++; $display("FAIL b2b_lw: got %h expected 12340000", c_rd); end
  endtask

  task automatic test_backpressure();
    int w;
    req_addr = 32'h8000_0008; req_size = 2'd2; req_wen = 1'b0; req_unsigned = 1'b0;
    req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w = 0;
    while (!resp_valid && w < 20) begin @(posedge clk); #1; w++; end
    n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_reach_resp: got %b expected 1", resp_valid); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, resp_valid); end
      n_cmp++; if (resp_rdata !== 32'h80FF_7F01) begin n_bad++; $display("FAIL bp_rdata[%0d]: got %h expected 80ff7f01", i, resp_rdata); end
      n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL bp_err[%0d]: got %b expected 0", i, resp_err); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req_ready[%0d]: got %b expected 0", i, req_ready); end
      n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL bp_mem_valid[%0d]: got %b expected 0", i, mem_valid); end
      req_valid = (i == 2); req_addr = 32'h8000_0000; req_wen = 1'b1;
      req_wdata = 32'hFFFF_FFFF; req_size = 2'd2;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_wen = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    n_cmp++; if ({req_ready, resp_valid, mem_valid} !== 3'b100) begin n_bad++; $display("FAIL bp_after: got ready=%b valid=%b mv=%b expected 1/0/0", req_ready, resp_valid, mem_valid); end
    run_req(32'h8000_0000, 32'h0, 1'b0, 2'd2, 1'b0);
    n_cmp++; if (c_rd !== 32'hAB00_0000) begin n_bad++; $display("FAIL bp_no_store: got %h expected ab000000", c_rd); end
  endtask

  task automatic test_async_reset();
    logic seen;
    req_addr = 32'h8000_0004; req_size = 2'd2; req_wen = 1'b0; req_unsigned = 1'b0;
    req_valid = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++; if (mem_valid !== 1'b1) begin n_bad++; $display("FAIL ar_in_req: got %b expected 1", mem_valid); end
    rst = 1'b0;
    #1;
    n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL ar_mem_valid: got %b expected 0", mem_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ar_req_ready: got %b expected 1", req_ready); end
    #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid || mem_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL ar_no_resp: got %b expected 0", seen); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ar_idle: got %b expected 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_ext_loads();
    test_misalign();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the single-port synchronous SRAM responder on behalf of the execute stage.
- Accepts one load/store request at a time over a valid/ready handshake.
- Aligns addresses, generates byte-lane write masks and shifted write data, and issues a one-cycle memory access.
- Captures the registered read data, then sign- or zero-extends it and returns a response over a second valid/ready handshake.

Parameters:
- RD_LATENCY, 1: cycles from the mem_valid cycle to the cycle in which mem_rdata holds the result. Legal range is 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_wen  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- req_unsigned  in  1  load zero-extends when 1
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal-size access
- mem_raddr  out  32  word-aligned read address
- mem_waddr  out  32  word-aligned write address
- mem_wdata  out  32  lane-shifted store data
- mem_wmask  out  8  byte-lane enables; bits [7:4] are always 0
- mem_wen  out  1  write enable
- mem_valid  out  1  access strobe
- mem_rdata  in  32  registered SRAM read data

Behaviour:
- Reset state (rst=0):
  - Takes effect immediately. State goes to IDLE; the latency counter and all captured registers clear.
  - Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_valid=0, mem_wen=0, mem_wmask=0, and all mem address/data outputs 0.
  - Reset mid-access drops mem_valid in the same cycle; no partial response is ever produced.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1; all other outputs idle.
  - On req_valid & req_ready, latch addr, wdata, wen, size and unsigned.
  - Aligned request -> REQ. Misaligned or illegal request -> RESP with err=1.
- Misalignment rules:
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - size=3 is always illegal
  - Errored requests never assert mem_valid.
- REQ (exactly 1 cycle):
  - mem_valid=1.
  - mem_raddr = mem_waddr = {addr[31:2],2'b00}.
  - mem_wen = wen.
  - mem_wmask, only when wen=1 (otherwise 0):
    - byte: 8'h01 << addr[1:0]
    - half: 8'h03 << addr[1:0]
    - word: 8'h0F
  - mem_wdata = wdata << (8*addr[1:0]).
  - Load counter with RD_LATENCY-1, then -> WAIT.
- WAIT:
  - mem_valid=0 and mem_wen=0.
  - When counter==0, sample mem_rdata and -> RESP; otherwise decrement.
  - Load extraction:
    - shifted = mem_rdata >> (8*addr[1:0])
    - byte uses shifted[7:0]; half uses shifted[15:0]; word uses the full value.
    - Sign-extend from the top bit unless unsigned=1.
  - Stores: resp_rdata=0, and the read data is ignored.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_valid & resp_ready.
  - On that handshake -> IDLE.
  - req_ready=0 in REQ, WAIT and RESP; there is no request/response overlap.
- Latency:
  - Aligned access: resp_valid rises RD_LATENCY+2 cycles after the accept edge (3 cycles for the default).
  - Errored access: resp_valid rises 1 cycle after the accept edge.
- Back-to-back: a new request can be accepted in the cycle after the resp handshake, since req_ready=1 in IDLE.
- Ignored inputs: resp_ready outside RESP, and req_* outside IDLE.

Decomposition:
- Shared package:
  - size encodings (SZ_B, SZ_H, SZ_W)
  - FSM state enum
  - WMASK_W=8 and XLEN=32 constants
- One natural combinational sub-module, lsu_align: given addr[1:0], size, unsigned and wen, it produces mem_wmask, mem_wdata, the misalignment flag and the extended load data.

Test Plan:
- Word store then load:
  - store addr=0x8000_0004, wdata=0xDEADBEEF, size=2 -> REQ cycle shows mem_waddr=0x8000_0004, wmask=0x0F, wen=1, mem_valid=1; resp_err=0.
  - A following load of the same address returns resp_rdata=0xDEADBEEF, with resp_valid 3 cycles after accept.
- Byte store lane: store addr=0x8000_0003, wdata=0x000000AB, size=0 -> mem_wmask=0x08, mem_wdata=0xAB000000, mem_waddr=0x8000_0000.
- Signed/unsigned loads from mem_rdata=0x80FF7F01:
  - lb at addr 0x..1 with unsigned=0 -> 0x0000007F
  - lb at addr 0x..3 with unsigned=0 -> 0xFFFFFF80
  - lhu at addr 0x..2 -> 0x000080FF
  - lh at addr 0x..2 -> 0xFFFF80FF
- Misalignment: lw at 0x8000_0002 -> resp_err=1, resp_rdata=0, mem_valid never asserted, resp_valid 1 cycle after accept. Same for size=3.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stay stable, req_ready=0 throughout, and a req_valid pulse during RESP is not accepted.
- Async reset: drop rst during REQ -> mem_valid=0 in that same cycle without a clock edge. After rst=1, req_ready=1 and no response appears.
